cpu_mem_responder: RTL and testbench
====================================

// Module: cpu_mem_responder
// PURPOSE
//  Memory-side responder for the 8-bit accumulator CPU bus: services its mem_addr/mem_data/mem_write
//  requests from an internal 2**ADDR_W x DATA_W RAM with one-cycle registered read latency.
//  Embeds a byte-stream program loader that fills RAM from address 0 while holding the CPU stopped.
//  Sits between the CPU bus and the board-level loader (UART/JTAG bridge); cpu_run gates the CPU.
// PARAMETERS
//  ADDR_W        8      address width; RAM depth = 2**ADDR_W
//  DATA_W        8      data width
//  LOAD_ON_RESET 1      1: leave reset in IDLE (CPU held) awaiting load; 0: leave reset in RUN
//  GUARD_LIMIT   8'h80  addresses below this are CPU-write-protected (only with MEM_WRITE_GUARD_EN)
// PORTS
//  clk            in   1       clock; all state updates on posedge
//  async_nreset   in   1       asynchronous, active-low reset
//  mem_addr_in    in   ADDR_W  CPU address (CPU mem_addr_out)
//  mem_wdata_in   in   DATA_W  CPU write data (CPU mem_data_out)
//  mem_write_in   in   1       CPU write strobe, one cycle per write
//  mem_rdata_out  out  DATA_W  read data to CPU (CPU mem_data_in), registered
//  load_start     in   1       pulse: begin program load at address 0
//  load_valid     in   1       loader byte valid
//  load_data      in   DATA_W  loader byte
//  load_last      in   1       qualifies final byte of image (with load_valid)
//  load_ready     out  1       loader may transfer
//  load_err       out  1       sticky: image overran RAM depth
//  cpu_run        out  1       1 = CPU may execute; 0 = CPU must be held in reset
//  guard_fault    out  1       one-cycle pulse on dropped protected CPU write
// BEHAVIOUR
//  Reset: mem_rdata_out=0, load_ready=0, load_err=0, guard_fault=0, ptr=0;
//   state=IDLE if LOAD_ON_RESET else RUN; cpu_run=(state==RUN). RAM contents are NOT reset.
//  Read: every posedge mem_rdata_out <= RAM[mem_addr_in]; address in cycle N -> data valid cycle N+1.
//   No read strobe; reads occur every cycle in all states.
//  Write-first: RAM write and read of the same address in one cycle returns the new data.
//  CPU write: state==RUN && mem_write_in -> RAM[mem_addr_in] <= mem_wdata_in at posedge.
//   CPU writes in IDLE/LOAD are ignored silently (no fault).
//  FSM states IDLE, LOAD, RUN (registered; cpu_run and load_ready decoded from state):
//   IDLE: cpu_run=0, load_ready=0; load_start -> LOAD.
//   RUN : cpu_run=1, load_ready=0; load_start -> LOAD (stops the CPU next cycle).
//   LOAD: cpu_run=0, load_ready=1; entry clears ptr to 0 and load_err to 0.
//    load_valid&&load_ready: RAM[ptr] <= load_data, ptr <= ptr+1 (wraps modulo depth).
//    Accepted byte with load_last -> RUN next cycle.
//    Accepted byte at ptr==2**ADDR_W-1 without load_last -> RUN, load_err <= 1 (sticky).
//    load_start while in LOAD ignored; load_valid outside LOAD ignored.
//  Loader write and CPU write never coincide (CPU writes require RUN).
//  Reset mid-load: FSM/flags return to reset values; bytes already written stay in RAM.
// CONFIGURATION
//  MEM_WRITE_GUARD_EN defined: RUN-state CPU write with mem_addr_in < GUARD_LIMIT is dropped and
//   guard_fault pulses high for exactly the following cycle; loader writes are never guarded.
//  MEM_WRITE_GUARD_EN undefined: all RUN-state CPU writes land; guard_fault constant 0.
// TESTING
//  1 LOAD_ON_RESET=1: release reset -> cpu_run=0, load_ready=0; pulse load_start -> load_ready=1.
//  2 Load 3 bytes 8'h01,8'h80,8'hF0 (last on 3rd) -> cpu_run=1 next cycle; addr 0..2 read back
//    01,80,F0 each one cycle after address applied; load_err=0.
//  3 RUN: write 8'hA5 to 8'hC0 while reading 8'hC0 same cycle -> mem_rdata_out=A5 next cycle.
//  4 Stream 256 bytes, no load_last -> RUN after byte 255, load_err=1; new load_start clears it.
//  5 Guard en: CPU write 8'h55 to 8'h10 -> RAM[10] unchanged, guard_fault 1 cycle; 8'h90 lands.
//    Guard off: same write lands, guard_fault stays 0.
//  6 Assert async_nreset low after 2 loader bytes -> outputs at reset values immediately;
//    RAM[0..1] retain loaded bytes.

Source files
------------

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the accumulator CPU bus: RAM with registered reads plus a program loader.
// Optional CPU write protection of low addresses is enabled by defining MEM_WRITE_GUARD_EN.
module cpu_mem_responder #(
  parameter int unsigned       ADDR_W        = 8,
  parameter int unsigned       DATA_W        = 8,
  parameter bit                LOAD_ON_RESET = 1'b1,
  parameter logic [ADDR_W-1:0] GUARD_LIMIT   = 8'h80
) (
  input  logic              clk,
  input  logic              async_nreset,
  input  logic [ADDR_W-1:0] mem_addr_in,
  input  logic [DATA_W-1:0] mem_wdata_in,
  input  logic              mem_write_in,
  output logic [DATA_W-1:0] mem_rdata_out,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_err,
  output logic              cpu_run,
  output logic              guard_fault
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

`ifdef MEM_WRITE_GUARD_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam state_t RESET_STATE = LOAD_ON_RESET ? ST_IDLE : ST_RUN;

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];
  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_load_err;
  logic              r_guard_fault;

  logic              w_load_acc;
  logic              w_ptr_at_end;
  logic              w_load_entry;
  logic              w_guard_hit;
  logic              w_cpu_we;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;

  assign w_load_acc   = (r_state == ST_LOAD) && load_valid;
  assign w_ptr_at_end = (r_ptr == {ADDR_W{1'b1}});
  assign w_load_entry = (r_state != ST_LOAD) && (w_state_nxt == ST_LOAD);
  assign w_guard_hit  = GUARD_EN && (r_state == ST_RUN) && mem_write_in &&
                        (mem_addr_in < GUARD_LIMIT);
  assign w_cpu_we     = (r_state == ST_RUN) && mem_write_in && !w_guard_hit;

  assign cpu_run     = (r_state == ST_RUN);
  assign load_ready  = (r_state == ST_LOAD);
  assign load_err    = r_load_err;
  assign guard_fault = r_guard_fault;

  // Single RAM write port shared by loader and CPU; they are never active together.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = mem_addr_in;
    w_wdata = mem_wdata_in;
    if (w_load_acc) begin
      w_we    = 1'b1;
      w_waddr = r_ptr;
      w_wdata = load_data;
    end else if (w_cpu_we) begin
      w_we    = 1'b1;
    end else begin
      w_we    = 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (load_start) w_state_nxt = ST_LOAD;
        else            w_state_nxt = ST_IDLE;
      end
      ST_LOAD: begin
        if (w_load_acc && (load_last || w_ptr_at_end)) w_state_nxt = ST_RUN;
        else                                           w_state_nxt = ST_LOAD;
      end
      ST_RUN: begin
        if (load_start) w_state_nxt = ST_LOAD;
        else            w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      r_state <= RESET_STATE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // RAM contents deliberately survive reset so a partially loaded image stays visible.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      mem_rdata_out <= {DATA_W{1'b0}};
    end else if (w_we && (w_waddr == mem_addr_in)) begin
      mem_rdata_out <= w_wdata;
    end else begin
      mem_rdata_out <= r_mem[mem_addr_in];
    end
  end

  // Overrun without load_last ends the load but leaves a sticky error until the next load starts.
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      r_ptr         <= {ADDR_W{1'b0}};
      r_load_err    <= 1'b0;
      r_guard_fault <= 1'b0;
    end else begin
      r_guard_fault <= w_guard_hit;
      if (w_load_entry) begin
        r_ptr      <= {ADDR_W{1'b0}};
        r_load_err <= 1'b0;
      end else if (w_load_acc) begin
        r_ptr <= r_ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (!load_last && w_ptr_at_end) r_load_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed self-checking bench for cpu_mem_responder (default parameters).
module tb_cpu_mem_responder;

  logic       clk;
  logic       async_nreset;
  logic [7:0] mem_addr_in;
  logic [7:0] mem_wdata_in;
  logic       mem_write_in;
  logic [7:0] mem_rdata_out;
  logic       load_start;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       load_ready;
  logic       load_err;
  logic       cpu_run;
  logic       guard_fault;

  int n_checks = 0;
  int n_errors = 0;

`ifdef MEM_WRITE_GUARD_EN
  localparam bit GUARD_ON = 1'b1;
`else
  localparam bit GUARD_ON = 1'b0;
`endif

  cpu_mem_responder dut (
    .clk          (clk),
    .async_nreset (async_nreset),
    .mem_addr_in  (mem_addr_in),
    .mem_wdata_in (mem_wdata_in),
    .mem_write_in (mem_write_in),
    .mem_rdata_out(mem_rdata_out),
    .load_start   (load_start),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_last    (load_last),
    .load_ready   (load_ready),
    .load_err     (load_err),
    .cpu_run      (cpu_run),
    .guard_fault  (guard_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic run, input logic rdy, input logic err);
    check({tag, "_cpu_run"}, {31'd0, cpu_run}, {31'd0, run});
    check({tag, "_load_ready"}, {31'd0, load_ready}, {31'd0, rdy});
    check({tag, "_load_err"}, {31'd0, load_err}, {31'd0, err});
  endtask

  initial begin
    logic [7:0] b;
    async_nreset = 1'b0;
    mem_addr_in  = 8'h00;
    mem_wdata_in = 8'h00;
    mem_write_in = 1'b0;
    load_start   = 1'b0;
    load_valid   = 1'b0;
    load_data    = 8'h00;
    load_last    = 1'b0;
    #1;
    check_flags("rst", 1'b0, 1'b0, 1'b0);
    check("rst_rdata", {24'd0, mem_rdata_out}, 32'h00);
    check("rst_guard", {31'd0, guard_fault}, 32'd0);
    tick();
    tick();
    async_nreset = 1'b1;
    tick();
    check_flags("idle", 1'b0, 1'b0, 1'b0);

    // Short image load
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check_flags("load_enter", 1'b0, 1'b1, 1'b0);
    load_valid = 1'b1;
    load_data  = 8'h01;
    tick();
    load_data  = 8'h80;
    tick();
    check_flags("load_mid", 1'b0, 1'b1, 1'b0);
    load_data  = 8'hF0;
    load_last  = 1'b1;
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
    check_flags("load_done", 1'b1, 1'b0, 1'b0);
    mem_addr_in = 8'h00;
    tick();
    check("rd0", {24'd0, mem_rdata_out}, 32'h01);
    mem_addr_in = 8'h01;
    tick();
    check("rd1", {24'd0, mem_rdata_out}, 32'h80);
    mem_addr_in = 8'h02;
    tick();
    check("rd2", {24'd0, mem_rdata_out}, 32'hF0);

    // Write-first on same address
    mem_addr_in  = 8'hC0;
    mem_wdata_in = 8'hA5;
    mem_write_in = 1'b1;
    tick();
    mem_write_in = 1'b0;
    check("wfirst", {24'd0, mem_rdata_out}, 32'hA5);
    tick();
    check("wfirst_hold", {24'd0, mem_rdata_out}, 32'hA5);

    // Full-depth overrun load without load_last
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      load_valid = 1'b1;
      load_data  = 8'(i) ^ 8'h5A;
      tick();
      if (i == 254) check_flags("ovr_254", 1'b0, 1'b1, 1'b0);
    end
    load_valid = 1'b0;
    check_flags("ovr_end", 1'b1, 1'b0, 1'b1);
    mem_addr_in = 8'h00;
    tick();
    check("ovr_rd00", {24'd0, mem_rdata_out}, 32'h5A);
    mem_addr_in = 8'hFF;
    tick();
    check("ovr_rdFF", {24'd0, mem_rdata_out}, 32'hA5);
    mem_addr_in = 8'hC0;
    tick();
    check("ovr_rdC0", {24'd0, mem_rdata_out}, 32'h9A);

    // Protected-range write (outcome depends on guard build)
    mem_addr_in  = 8'h10;
    mem_wdata_in = 8'h55;
    mem_write_in = 1'b1;
    tick();
    mem_write_in = 1'b0;
    b = GUARD_ON ? 8'h4A : 8'h55;
    check("guard_rd", {24'd0, mem_rdata_out}, {24'd0, b});
    check("guard_pulse", {31'd0, guard_fault}, {31'd0, GUARD_ON});
    tick();
    check("guard_rd_hold", {24'd0, mem_rdata_out}, {24'd0, b});
    check("guard_pulse_end", {31'd0, guard_fault}, 32'd0);
    mem_addr_in  = 8'h90;
    mem_wdata_in = 8'h66;
    mem_write_in = 1'b1;
    tick();
    mem_write_in = 1'b0;
    check("unguard_rd", {24'd0, mem_rdata_out}, 32'h66);
    check("unguard_fault", {31'd0, guard_fault}, 32'd0);

    // New load clears sticky error; CPU writes in LOAD are ignored
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check_flags("reload", 1'b0, 1'b1, 1'b0);
    mem_addr_in  = 8'h20;
    mem_wdata_in = 8'hEE;
    mem_write_in = 1'b1;
    tick();
    mem_write_in = 1'b0;
    check("load_cpuwr_ign", {24'd0, mem_rdata_out}, 32'h7A);

    // Reset in the middle of a load
    load_valid = 1'b1;
    load_data  = 8'hDE;
    tick();
    load_data  = 8'hAD;
    tick();
    load_valid = 1'b0;
    #2;
    async_nreset = 1'b0;
    #1;
    check_flags("midrst", 1'b0, 1'b0, 1'b0);
    check("midrst_rdata", {24'd0, mem_rdata_out}, 32'h00);
    check("midrst_guard", {31'd0, guard_fault}, 32'd0);
    tick();
    async_nreset = 1'b1;
    load_valid   = 1'b1;
    load_data    = 8'hFF;
    mem_addr_in  = 8'h03;
    tick();
    load_valid = 1'b0;
    check("idle_rd3", {24'd0, mem_rdata_out}, 32'h59);
    check_flags("idle_valid_ign", 1'b0, 1'b0, 1'b0);
    mem_addr_in = 8'h00;
    tick();
    check("keep_rd0", {24'd0, mem_rdata_out}, 32'hDE);
    mem_addr_in = 8'h01;
    tick();
    check("keep_rd1", {24'd0, mem_rdata_out}, 32'hAD);
    mem_addr_in = 8'h02;
    tick();
    check("keep_rd2", {24'd0, mem_rdata_out}, 32'h58);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
